// File: rtl/draw_rect_ctl_pkg.sv
// Shared types and sizing for the draw_rect motion controller.
// Contents:
//   state_t   - controller state (FOLLOW / FALL / REST), 2-bit encoding
//   POS_W     - pixel coordinate width
//   VEL_W     - signed vertical velocity width
//   ARITH_W   - signed width used for position + velocity sums
//   span_max  - largest top-left coordinate that keeps the rectangle on screen
package draw_rect_ctl_pkg;

  localparam int POS_W   = 12;
  localparam int VEL_W   = 8;
  localparam int ARITH_W = POS_W + 1;

  typedef enum logic [1:0] {
    FOLLOW = 2'd0,
    FALL   = 2'd1,
    REST   = 2'd2
  } state_t;

  function automatic logic [POS_W-1:0] span_max(input int screen, input int rect);
    return POS_W'(screen - rect);
  endfunction

endpackage

// File: rtl/draw_rect_ctl_sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears all flops
//   din   - asynchronous (or foreign-domain) level input
//   pulse - one-cycle high pulse after a synchronised 0->1 transition of din
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  end

  assign pulse = sync[1] & ~prev;

endmodule

// File: rtl/draw_rect_ctl.sv
// Frame-paced motion controller feeding draw_rect.
// FOLLOW tracks the mouse (clamped so the rectangle stays on screen); a click
// drops the rectangle under gravity (FALL) with damped floor bounces until it
// settles (REST); another click returns to FOLLOW. All updates happen on the
// vsync frame tick and outputs are registered, so they are stable per frame.
// Ports:
//   clk_in      - 40 MHz pixel clock
//   rst         - asynchronous active-low reset (release synchronised here)
//   vsync_in    - vsync from vga_timing; its rising edge is the frame tick
//   mouse_xpos  - mouse X (12 bit, quasi-static)
//   mouse_ypos  - mouse Y (12 bit, quasi-static)
//   mouse_left  - left button, asynchronous to clk_in
//   xpos, ypos  - rectangle top-left corner for draw_rect
//   state_out   - current state: 0 FOLLOW, 1 FALL, 2 REST
module draw_rect_ctl
  import draw_rect_ctl_pkg::*;
#(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int RECT_W     = 64,
  parameter int RECT_H     = 48,
  parameter int GRAVITY    = 1,
  parameter int VEL_MAX    = 40,
  parameter int DAMP_SHIFT = 1,
  parameter int MIN_BOUNCE = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic [POS_W-1:0] mouse_xpos,
  input  logic [POS_W-1:0] mouse_ypos,
  input  logic             mouse_left,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [1:0]       state_out
);

  localparam logic [POS_W-1:0]          X_MAX        = span_max(SCREEN_W, RECT_W);
  localparam logic [POS_W-1:0]          Y_MAX        = span_max(SCREEN_H, RECT_H);
  localparam logic signed [ARITH_W-1:0] Y_MAX_S      = $signed({1'b0, Y_MAX});
  localparam logic signed [VEL_W-1:0]   GRAV_V       = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0]   VEL_MAX_V    = VEL_W'(VEL_MAX);
  localparam logic signed [VEL_W-1:0]   MIN_BOUNCE_V = VEL_W'(MIN_BOUNCE);

  // Reset asserts immediately, releases two clocks later so every flop
  // leaves reset on the same edge.
  logic [1:0] rst_pipe;
  logic       rst_n_int;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n_int = rst_pipe[1];

  logic tick;
  logic click;

  sync_edge_det u_vsync_edge (
    .clk   (clk_in),
    .rst_n (rst_n_int),
    .din   (vsync_in),
    .pulse (tick)
  );

  sync_edge_det u_click_edge (
    .clk   (clk_in),
    .rst_n (rst_n_int),
    .din   (mouse_left),
    .pulse (click)
  );

  state_t                    state_q, state_d;
  logic [POS_W-1:0]          xpos_q, xpos_d;
  logic [POS_W-1:0]          ypos_q, ypos_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic                      click_pend_q, click_pend_d;
  logic                      pend_clear;

  logic signed [ARITH_W-1:0] ny;
  logic signed [VEL_W-1:0]   vel_inc;
  logic signed [VEL_W-1:0]   vel_capped;
  logic signed [VEL_W-1:0]   rebound;
  logic [POS_W-1:0]          x_clamp;
  logic [POS_W-1:0]          y_clamp;

  // Candidate position sums are signed and one bit wider so a rise past the
  // top edge shows up as a negative value instead of wrapping.
  assign ny         = $signed({1'b0, ypos_q}) +
                      $signed({{(ARITH_W-VEL_W){vel_q[VEL_W-1]}}, vel_q});
  assign vel_inc    = vel_q + GRAV_V;
  assign vel_capped = (vel_inc > VEL_MAX_V) ? VEL_MAX_V : vel_inc;
  assign rebound    = vel_q - (vel_q >>> DAMP_SHIFT);
  assign x_clamp    = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
  assign y_clamp    = (mouse_ypos > Y_MAX) ? Y_MAX : mouse_ypos;

  always_comb begin
    state_d    = state_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    vel_d      = vel_q;
    pend_clear = 1'b0;

    if (tick) begin
      case (state_q)
        FOLLOW: begin
          xpos_d = x_clamp;
          ypos_d = y_clamp;
          if (click_pend_q) begin
            pend_clear = 1'b1;
            vel_d      = '0;
            state_d    = FALL;
          end
        end
        FALL: begin
          // Clicks arriving while falling are thrown away at each tick.
          pend_clear = 1'b1;
          if (ny >= Y_MAX_S) begin
            ypos_d = Y_MAX;
            if (rebound < MIN_BOUNCE_V) begin
              vel_d   = '0;
              state_d = REST;
            end else begin
              vel_d = -rebound;
            end
          end else if (ny[ARITH_W-1]) begin
            ypos_d = '0;
            vel_d  = '0;
          end else begin
            ypos_d = ny[POS_W-1:0];
            vel_d  = vel_capped;
          end
        end
        REST: begin
          if (click_pend_q) begin
            pend_clear = 1'b1;
            state_d    = FOLLOW;
          end
        end
        default: state_d = FOLLOW;
      endcase
    end

    // A click coinciding with a tick survives the clear and acts next frame.
    click_pend_d = (click_pend_q & ~pend_clear) | click;
  end

  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= FOLLOW;
      xpos_q       <= '0;
      ypos_q       <= '0;
      vel_q        <= '0;
      click_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      vel_q        <= vel_d;
      click_pend_q <= click_pend_d;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Self-checking bench for draw_rect_ctl: frame-level behavioural model,
// expected-output queue and an independent output monitor.
module tb_draw_rect_ctl;

  localparam int W = 84;  // {due_cycle[31:0], before[25:0], after[25:0]}

  logic        clk;
  logic        rst;
  logic        vsync_in;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [1:0]  state_out;

  draw_rect_ctl dut (
    .clk_in     (clk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos),
    .state_out  (state_out)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (frame level) ----------------
  int m_state, m_x, m_y, m_vel;
  bit m_pend;

  function automatic void model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_vel = 0; m_pend = 0;
  endfunction

  function automatic logic [25:0] model_out();
    logic [11:0] x12, y12;
    logic [1:0]  s2;
    x12 = 12'(m_x); y12 = 12'(m_y); s2 = 2'(m_state);
    return {x12, y12, s2};
  endfunction

  function automatic void model_tick(input int mx, input int my);
    int ny, r;
    case (m_state)
      0: begin
        m_x = (mx < 736) ? mx : 736;
        m_y = (my < 552) ? my : 552;
        if (m_pend) begin m_pend = 0; m_vel = 0; m_state = 1; end
      end
      1: begin
        m_pend = 0;
        ny = m_y + m_vel;
        if (ny >= 552) begin
          m_y = 552;
          r = m_vel - m_vel / 2;
          if (r < 2) begin m_vel = 0; m_state = 2; end
          else m_vel = -r;
        end else if (ny < 0) begin
          m_y = 0; m_vel = 0;
        end else begin
          m_y = ny;
          m_vel = (m_vel + 1 > 40) ? 40 : m_vel + 1;
        end
      end
      default: begin
        if (m_pend) begin m_pend = 0; m_state = 0; end
      end
    endcase
  endfunction

  // ---------------- monitor ----------------
  // Outputs must hold the previous frame's values the cycle before the
  // expected update and show the new values from the update cycle on.
  always @(negedge clk) begin
    logic [W-1:0] item;
    int due;
    if (exp_q.size() > 0) begin
      item = exp_q[0];
      due = int'(item[83:52]);
      if (cyc == due - 1) begin
        check("hold_before_update", {6'd0, xpos, ypos, state_out}, {6'd0, item[51:26]});
      end else if (cyc == due) begin
        check("after_tick", {6'd0, xpos, ypos, state_out}, {6'd0, item[25:0]});
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic frame(input int mx, input int my, input bit with_click);
    int c;
    logic [25:0] pre;
    @(negedge clk);
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    c = cyc;
    pre = model_out();
    vsync_in = 1'b1;
    if (with_click) mouse_left = 1'b1;
    model_tick(mx, my);
    if (with_click) m_pend = 1;
    exp_q.push_back({32'(c + 3), pre, model_out()});
    @(negedge clk);
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    vsync_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic click(input int hi);
    @(negedge clk);
    mouse_left = 1'b1;
    repeat (hi) @(negedge clk);
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    m_pend = 1;
  endtask

  task automatic fall_until_rest(input int budget);
    for (int i = 0; i < budget && m_state != 2; i++)
      frame($urandom_range(0, 1023), $urandom_range(0, 1023), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    vsync_in = 1'b0;
    mouse_xpos = '0;
    mouse_ypos = '0;
    mouse_left = 1'b0;
    model_reset();

    #3 rst = 1'b0;
    #2;
    check("reset_xpos", 32'(xpos), 32'd0);
    check("reset_ypos", 32'(ypos), 32'd0);
    check("reset_state", 32'(state_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Follow with clamping, then in range
    frame(900, 700, 0);
    frame(100, 200, 0);

    // Reset mid-fall at ypos=300
    frame(100, 300, 0);
    click(1);
    frame(100, 300, 0);
    frame(500, 500, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midfall_reset_xpos", 32'(xpos), 32'd0);
    check("midfall_reset_ypos", 32'(ypos), 32'd0);
    check("midfall_reset_state", 32'(state_out), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_release_state", 32'(state_out), 32'd0);
    frame(40, 50, 0);

    // Drop from y=100; a click mid-fall must be discarded
    frame(100, 100, 0);
    click(1);
    frame(100, 100, 0);
    for (int i = 0; i < 5; i++) frame($urandom_range(0, 1023), $urandom_range(0, 1023), 0);
    click(2);
    fall_until_rest(200);
    frame(10, 10, 0);
    frame(20, 20, 0);

    // Three glitchy clicks in one REST frame -> a single return to FOLLOW
    click(1);
    click(2);
    click(1);
    frame(300, 400, 0);
    frame(300, 400, 0);
    frame(310, 410, 0);

    // Drop from y=500 with damped bounces
    frame(200, 500, 0);
    click(1);
    frame(200, 500, 0);
    fall_until_rest(100);

    // Click coincident with a tick acts only on the following tick
    frame(50, 60, 1);
    frame(50, 60, 0);
    frame(70, 80, 0);

    // Randomised frames
    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) click($urandom_range(1, 2));
      end
      frame($urandom_range(0, 1023), $urandom_range(0, 1023), sel == 1);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected updates never observed, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
